// File: rtl/hazard_controller.sv
// hazard_controller
//   Hazard and forwarding control for the 5-stage pipelined core.
//   Forwarding selects for the EX operand MUX3s and the ID branch-compare
//   MUX2s, stall/flush for the F/D/E pipeline registers, and a busy tracker
//   for the multi-cycle multiply/divide unit (MDU).
//
//   state | meaning
//   IDLE  | no MDU op outstanding, HI/LO valid
//   BUSY  | MDU op in flight, cnt counts down to the result-ready cycle
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   rs_d, rt_d, rs_e, rt_e        source registers in ID / EX
//   write_reg_e/_m/_w             destination register in EX / MEM / WB
//   reg_write_e/_m/_w             stage instruction writes the register file
//   mem_to_reg_e/_m               stage instruction is a load
//   branch_d, jr_d, pcsrc_d       ID branch/jump type and PC redirect
//   md_op_d, md_read_d            ID instr is an MDU op / reads HI/LO
//   md_start_e                    MDU op issues in EX this cycle
//   forward_a_e, forward_b_e      EX operand selects (00 RF, 01 WB, 10 MEM)
//   forward_a_d, forward_b_d      ID compare selects (0 RF, 1 MEM)
//   stall_f, stall_d, flush_d, flush_e   pipeline register control
//   md_busy                       MDU result not yet valid (registered)
module hazard_controller #(
   parameter int MDU_CYCLES = 32,
   parameter int CW         = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   input  logic [4:0] rs_e,
   input  logic [4:0] rt_e,
   input  logic [4:0] write_reg_e,
   input  logic [4:0] write_reg_m,
   input  logic [4:0] write_reg_w,
   input  logic       reg_write_e,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   input  logic       mem_to_reg_e,
   input  logic       mem_to_reg_m,
   input  logic       branch_d,
   input  logic       jr_d,
   input  logic       pcsrc_d,
   input  logic       md_op_d,
   input  logic       md_read_d,
   input  logic       md_start_e,
   output logic [1:0] forward_a_e,
   output logic [1:0] forward_b_e,
   output logic       forward_a_d,
   output logic       forward_b_d,
   output logic       stall_f,
   output logic       stall_d,
   output logic       flush_d,
   output logic       flush_e,
   output logic       md_busy
);

   typedef enum logic {IDLE, BUSY} md_state_t;

   md_state_t     state;
   logic [CW-1:0] cnt;

   logic lw_stall;
   logic br_stall;
   logic md_stall;
   logic stall;
   logic hit_e;
   logic hit_m;

   always_comb begin
      forward_a_e = 2'b00;
      if (rs_e != 5'd0 && reg_write_m && rs_e == write_reg_m)
         forward_a_e = 2'b10;
      else if (rs_e != 5'd0 && reg_write_w && rs_e == write_reg_w)
         forward_a_e = 2'b01;

      forward_b_e = 2'b00;
      if (rt_e != 5'd0 && reg_write_m && rt_e == write_reg_m)
         forward_b_e = 2'b10;
      else if (rt_e != 5'd0 && reg_write_w && rt_e == write_reg_w)
         forward_b_e = 2'b01;

      forward_a_d = (rs_d != 5'd0) && reg_write_m && (rs_d == write_reg_m);
      forward_b_d = (rt_d != 5'd0) && reg_write_m && (rt_d == write_reg_m);
   end

   always_comb begin
      lw_stall = mem_to_reg_e && (write_reg_e != 5'd0) &&
                 ((rs_d == write_reg_e) || (rt_d == write_reg_e));

      // jr only reads rs in ID; beq/bne compare both operands.
      hit_e = reg_write_e && (write_reg_e != 5'd0) &&
              ((write_reg_e == rs_d) || (branch_d && write_reg_e == rt_d));
      hit_m = mem_to_reg_m && (write_reg_m != 5'd0) &&
              ((write_reg_m == rs_d) || (branch_d && write_reg_m == rt_d));
      br_stall = (branch_d || jr_d) && (hit_e || hit_m);

      // md_start_e covers the issue cycle, before md_busy has risen.
      md_stall = (md_read_d || md_op_d) && (md_busy || md_start_e);

      stall   = lw_stall || br_stall || md_stall;
      stall_f = stall;
      stall_d = stall;
      flush_e = stall;
      // A stalled branch has not resolved yet, so it must not flush.
      flush_d = pcsrc_d && !stall;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         md_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (md_start_e) begin
                  cnt     <= CW'(MDU_CYCLES - 1);
                  state   <= BUSY;
                  md_busy <= 1'b1;
               end
            end
            BUSY: begin
               if (md_start_e) begin
                  cnt <= CW'(MDU_CYCLES - 1);
               end else if (cnt == CW'(1)) begin
                  cnt     <= '0;
                  state   <= IDLE;
                  md_busy <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               md_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
